// File: rtl/msrh_l1d_refill_unit.sv
// L1D refill unit: buffers L2 refill responses, looks up the LRQ line address,
// writes the line into the L1D arrays and then frees the LRQ entry.
module msrh_l1d_refill_unit #(
  parameter int   LRQ_ENTRY_SIZE   = 8,
  parameter int   L2_CMD_TAG_W     = 8,
  parameter logic L2_UPPER_TAG_L1D = 1'b0,
  parameter int   PADDR_W          = 56,
  parameter int   LINE_W           = 512,
  parameter int   FIFO_DEPTH       = 2
) (
  input  logic                          i_clk,
  input  logic                          i_reset,
  input  logic                          i_resp_valid,
  output logic                          o_resp_ready,
  input  logic [L2_CMD_TAG_W-1:0]       i_resp_tag,
  input  logic [LINE_W-1:0]             i_resp_data,
  output logic                          o_search_valid,
  output logic [$clog2(LRQ_ENTRY_SIZE)-1:0] o_search_index,
  input  logic [PADDR_W-1:0]            i_search_paddr,
  output logic                          o_wr_valid,
  input  logic                          i_wr_ready,
  output logic [PADDR_W-1:0]            o_wr_paddr,
  output logic [LINE_W-1:0]             o_wr_data,
  output logic                          o_release_valid,
  output logic [LRQ_ENTRY_SIZE-1:0]     o_release_index_oh,
  output logic                          o_tag_error,
  output logic                          o_busy
);

  localparam int IDX_W = $clog2(LRQ_ENTRY_SIZE);
  localparam int OFF_W = $clog2(LINE_W/8);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = $clog2(FIFO_DEPTH+1);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_SEARCH  = 2'd1;
  localparam logic [1:0] ST_WRITE   = 2'd2;
  localparam logic [1:0] ST_RELEASE = 2'd3;

  logic [IDX_W-1:0]   fifo_idx  [FIFO_DEPTH];
  logic [LINE_W-1:0]  fifo_data [FIFO_DEPTH];
  logic [PTR_W-1:0]   wr_ptr, rd_ptr;
  logic [CNT_W-1:0]   count;
  logic [1:0]         state;
  logic [PADDR_W-1:0] paddr_q;
  logic [IDX_W-1:0]   rel_idx;
  logic               tag_err_q;

  logic owner_ok, resp_fire, push, pop;

  // Explicit wrap so non-power-of-2 depths still cycle through every slot.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(FIFO_DEPTH-1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign owner_ok     = (i_resp_tag[L2_CMD_TAG_W-1] == L2_UPPER_TAG_L1D);
  assign o_resp_ready = (count < CNT_W'(FIFO_DEPTH));
  assign resp_fire    = i_resp_valid & o_resp_ready;
  assign push         = resp_fire & owner_ok;
  assign pop          = (state == ST_WRITE) & i_wr_ready;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= ptr_inc(wr_ptr);
      if (pop)  rd_ptr <= ptr_inc(rd_ptr);
      if (push && !pop)      count <= count + CNT_W'(1);
      else if (pop && !push) count <= count - CNT_W'(1);
    end
  end

  always_ff @(posedge i_clk) begin
    if (push) begin
      fifo_idx[wr_ptr]  <= i_resp_tag[IDX_W-1:0];
      fifo_data[wr_ptr] <= i_resp_data;
    end
  end

  // A push in IDLE starts the search next cycle without waiting for count.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state     <= ST_IDLE;
      paddr_q   <= '0;
      rel_idx   <= '0;
      tag_err_q <= 1'b0;
    end else begin
      tag_err_q <= resp_fire & ~owner_ok;
      case (state)
        ST_IDLE:    if (count != '0 || push) state <= ST_SEARCH;
        ST_SEARCH: begin
          paddr_q <= {i_search_paddr[PADDR_W-1:OFF_W], {OFF_W{1'b0}}};
          state   <= ST_WRITE;
        end
        ST_WRITE: begin
          if (i_wr_ready) begin
            rel_idx <= fifo_idx[rd_ptr];
            state   <= ST_RELEASE;
          end
        end
        ST_RELEASE: state <= ST_IDLE;
        default:    state <= ST_IDLE;
      endcase
    end
  end

  assign o_search_valid     = (state == ST_SEARCH);
  assign o_search_index     = o_search_valid ? fifo_idx[rd_ptr] : '0;
  assign o_wr_valid         = (state == ST_WRITE);
  assign o_wr_paddr         = o_wr_valid ? paddr_q : '0;
  assign o_wr_data          = o_wr_valid ? fifo_data[rd_ptr] : '0;
  assign o_release_valid    = (state == ST_RELEASE);
  assign o_release_index_oh = o_release_valid ? (LRQ_ENTRY_SIZE'(1) << rel_idx) : '0;
  assign o_tag_error        = tag_err_q;
  assign o_busy             = (count != '0) || (state != ST_IDLE);

endmodule
